// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   WIDTH    : default PC / instruction width
//   PC_STEP  : byte distance between sequential fetches
//   RESET_PC : default PC after reset
//   DEPTH    : default response-buffer depth (also the in-flight request limit)
//   fetch_entry_t : one buffered {pc, instr} pair handed to IF/ID
//   tag_t         : one outstanding request {pc, epoch}
package if_pkg;
    localparam int              WIDTH    = 32;
    localparam int              PC_STEP  = 4;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;
    localparam int              DEPTH    = 2;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
    } fetch_entry_t;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic             epoch;
    } tag_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   master : fetch unit (drives IMEM_REQ / IMEM_ADDR)
//   slave  : memory     (drives IMEM_GNT / IMEM_RVALID / IMEM_RDATA)
interface if_fetch_unit_if #(
    parameter int WIDTH = if_pkg::WIDTH
);
    logic             IMEM_REQ;
    logic [WIDTH-1:0] IMEM_ADDR;
    logic             IMEM_GNT;
    logic             IMEM_RVALID;
    logic [WIDTH-1:0] IMEM_RDATA;

    modport master (
        output IMEM_REQ, IMEM_ADDR,
        input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA
    );

    modport slave (
        input  IMEM_REQ, IMEM_ADDR,
        output IMEM_GNT, IMEM_RVALID, IMEM_RDATA
    );
endinterface

// File: rtl/if_fetch_unit_chk.sv
// Protocol checks for the fetch unit.
//   rvalid/tag_empty : response arriving with no outstanding request
//   tag_push/full    : request issued beyond the in-flight limit
//   buf_*            : response buffer overflow
module if_fetch_unit_chk (
    input logic clk,
    input logic rst,
    input logic rvalid,
    input logic tag_empty,
    input logic tag_push,
    input logic tag_full,
    input logic buf_push,
    input logic buf_pop,
    input logic buf_full
);
    a_rvalid_without_request: assert property (@(posedge clk) disable iff (rst)
        !(rvalid && tag_empty));

    a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
        !(tag_push && tag_full));

    a_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_push && buf_full && !buf_pop));
endmodule

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO used for both the in-order tag queue and the
// response buffer.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write one entry (accepted when not full, or when popping)
//   pop             : consume the head entry (ignored when empty)
//   flush           : discard all entries; wins over push and pop
//   head_data       : current head entry (undefined content when empty)
//   count/full/empty: occupancy status
module fetch_fifo #(
    parameter  int DW    = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign head_data = mem_r[rd_ptr_r];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush) mem_r[wr_ptr_r] <= push_data;
    end
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
//   clk, rst         : clock, asynchronous active-high reset
//   STALL            : downstream hold, head entry is kept
//   REDIRECT/_PC     : reload PC (word aligned) and discard all fetched work
//   imem             : instruction memory bus (master side)
//   PC_OUT/INSTRUCTION_OUT/VALID_OUT : buffer head toward IF/ID
//   FLUSH_OUT        : REDIRECT delayed by one cycle, flushes IF/ID
// Requests are credit limited: in-flight + buffered never exceeds DEPTH, so
// the response buffer cannot overflow. Each request carries the epoch it was
// issued in; a redirect flips the epoch so older responses are discarded.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int               WIDTH    = if_pkg::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(if_pkg::RESET_PC),
    parameter int               DEPTH    = if_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                STALL,
    input  logic                REDIRECT,
    input  logic [WIDTH-1:0]    REDIRECT_PC,
    if_fetch_unit_if.master     imem,
    output logic [WIDTH-1:0]    PC_OUT,
    output logic [WIDTH-1:0]    INSTRUCTION_OUT,
    output logic                VALID_OUT,
    output logic                FLUSH_OUT
);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int TAG_W = WIDTH + 1;
    localparam int ENT_W = 2 * WIDTH;

    logic [WIDTH-1:0] pc_r;
    logic             epoch_r;
    logic             flush_r;

    logic [TAG_W-1:0] tag_head_s;
    logic [CW-1:0]    tag_count_s;
    logic             tag_full_s;
    logic             tag_empty_s;
    logic [ENT_W-1:0] buf_head_s;
    logic [CW-1:0]    buf_count_s;
    logic             buf_full_s;
    logic             buf_empty_s;

    logic             credit_s;
    logic             grant_s;
    logic             tag_pop_s;
    logic             buf_push_s;
    logic             buf_pop_s;

    assign credit_s = ({1'b0, tag_count_s} + {1'b0, buf_count_s}) < (CW + 1)'(DEPTH);
    // rst gate keeps the request low while reset is held.
    assign imem.IMEM_REQ  = !rst && !REDIRECT && credit_s;
    assign imem.IMEM_ADDR = pc_r;
    assign grant_s        = imem.IMEM_REQ && imem.IMEM_GNT;

    // Responses always retire a tag; only current-epoch ones outside a
    // redirect cycle reach the buffer.
    assign tag_pop_s  = imem.IMEM_RVALID && !tag_empty_s;
    assign buf_push_s = tag_pop_s && (tag_head_s[0] == epoch_r) && !REDIRECT;
    assign buf_pop_s  = VALID_OUT && !STALL && !REDIRECT;

    fetch_fifo #(.DW(TAG_W), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_s),
        .push_data ({pc_r, epoch_r}),
        .pop       (tag_pop_s),
        .flush     (1'b0),
        .head_data (tag_head_s),
        .count     (tag_count_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s)
    );

    fetch_fifo #(.DW(ENT_W), .DEPTH(DEPTH)) u_resp_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push_s),
        .push_data ({tag_head_s[TAG_W-1:1], imem.IMEM_RDATA}),
        .pop       (buf_pop_s),
        .flush     (REDIRECT),
        .head_data (buf_head_s),
        .count     (buf_count_s),
        .full      (buf_full_s),
        .empty     (buf_empty_s)
    );

    // PC, epoch and flush pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            epoch_r <= 1'b0;
            flush_r <= 1'b0;
        end else begin
            flush_r <= REDIRECT;
            if (REDIRECT) begin
                pc_r    <= REDIRECT_PC & ~WIDTH'(2'b11);
                epoch_r <= ~epoch_r;
            end else if (grant_s) begin
                pc_r    <= pc_r + WIDTH'(PC_STEP);
            end
        end
    end

    assign FLUSH_OUT = flush_r;

    // Head of the response buffer, zeroed when empty.
    always_comb begin
        PC_OUT          = '0;
        INSTRUCTION_OUT = '0;
        VALID_OUT       = 1'b0;
        if (!buf_empty_s) begin
            PC_OUT          = buf_head_s[ENT_W-1:WIDTH];
            INSTRUCTION_OUT = buf_head_s[WIDTH-1:0];
            VALID_OUT       = 1'b1;
        end else begin
            VALID_OUT       = 1'b0;
        end
    end

    if_fetch_unit_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .rvalid    (imem.IMEM_RVALID),
        .tag_empty (tag_empty_s),
        .tag_push  (grant_s),
        .tag_full  (tag_full_s),
        .buf_push  (buf_push_s),
        .buf_pop   (buf_pop_s),
        .buf_full  (buf_full_s)
    );
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a one-cycle, in-order memory model.
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        STALL;
    logic        REDIRECT;
    logic [31:0] REDIRECT_PC;
    logic [31:0] PC_OUT;
    logic [31:0] INSTRUCTION_OUT;
    logic        VALID_OUT;
    logic        FLUSH_OUT;

    if_fetch_unit_if #(.WIDTH(32)) imem ();

    if_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .STALL           (STALL),
        .REDIRECT        (REDIRECT),
        .REDIRECT_PC     (REDIRECT_PC),
        .imem            (imem),
        .PC_OUT          (PC_OUT),
        .INSTRUCTION_OUT (INSTRUCTION_OUT),
        .VALID_OUT       (VALID_OUT),
        .FLUSH_OUT       (FLUSH_OUT)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_grants = 0;
    logic        mem_hold = 1'b0;
    logic [31:0] pending [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hAAAA_AAAA;
            32'h0000_0004: return 32'hBBBB_BBBB;
            32'h0000_0008: return 32'hCCCC_CCCC;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock: note what the DUT will see at the edge, update the memory
    // model after the edge, return at the following negedge.
    task automatic cycle();
        logic        gnt_now;
        logic        rv_now;
        logic [31:0] addr_now;
        #1;
        gnt_now  = imem.IMEM_REQ && imem.IMEM_GNT;
        rv_now   = imem.IMEM_RVALID;
        addr_now = imem.IMEM_ADDR;
        @(posedge clk);
        #1;
        if (gnt_now) n_grants++;
        if (rv_now && pending.size() > 0) void'(pending.pop_front());
        if (gnt_now) pending.push_back(addr_now);
        if (!mem_hold && pending.size() > 0) begin
            imem.IMEM_RVALID = 1'b1;
            imem.IMEM_RDATA  = mem_word(pending[0]);
        end else begin
            imem.IMEM_RVALID = 1'b0;
            imem.IMEM_RDATA  = 32'h0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        STALL            = 1'b0;
        REDIRECT         = 1'b0;
        REDIRECT_PC      = 32'h0;
        imem.IMEM_GNT    = 1'b0;
        imem.IMEM_RVALID = 1'b0;
        imem.IMEM_RDATA  = 32'h0;
        mem_hold         = 1'b0;
        n_grants         = 0;
        pending.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst              = 1'b1;
        STALL            = 1'b0;
        REDIRECT         = 1'b0;
        REDIRECT_PC      = 32'h0;
        imem.IMEM_GNT    = 1'b0;
        imem.IMEM_RVALID = 1'b0;
        imem.IMEM_RDATA  = 32'h0;
        #1;
        check_val("rst_req",   {31'b0, imem.IMEM_REQ}, 32'h0);
        check_val("rst_addr",  imem.IMEM_ADDR, 32'h0);
        check_val("rst_pc",    PC_OUT, 32'h0);
        check_val("rst_instr", INSTRUCTION_OUT, 32'h0);
        check_val("rst_valid", {31'b0, VALID_OUT}, 32'h0);
        check_val("rst_flush", {31'b0, FLUSH_OUT}, 32'h0);

        // Sequential fetch, 1-cycle memory.
        @(negedge clk);
        rst = 1'b0;
        imem.IMEM_GNT = 1'b1;
        #1;
        check_val("seq_req0",  {31'b0, imem.IMEM_REQ}, 32'h1);
        check_val("seq_addr0", imem.IMEM_ADDR, 32'h0);
        cycle();
        check_val("seq_addr1", imem.IMEM_ADDR, 32'h4);
        check_val("seq_v1",    {31'b0, VALID_OUT}, 32'h0);
        cycle();
        check_val("seq_addr2", imem.IMEM_ADDR, 32'h8);
        check_val("seq_pc0",   PC_OUT, 32'h0);
        check_val("seq_in0",   INSTRUCTION_OUT, 32'hAAAA_AAAA);
        check_val("seq_v2",    {31'b0, VALID_OUT}, 32'h1);
        check_val("seq_req2",  {31'b0, imem.IMEM_REQ}, 32'h0);
        cycle();
        check_val("seq_pc1",   PC_OUT, 32'h4);
        check_val("seq_in1",   INSTRUCTION_OUT, 32'hBBBB_BBBB);
        check_val("seq_req3",  {31'b0, imem.IMEM_REQ}, 32'h1);

        // Stall with full buffer, then drain.
        do_reset();
        imem.IMEM_GNT = 1'b1;
        STALL = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check_val("stl_grants", n_grants, 32'd2);
        check_val("stl_req",   {31'b0, imem.IMEM_REQ}, 32'h0);
        check_val("stl_addr",  imem.IMEM_ADDR, 32'h8);
        check_val("stl_pc",    PC_OUT, 32'h0);
        check_val("stl_in",    INSTRUCTION_OUT, 32'hAAAA_AAAA);
        STALL = 1'b0;
        cycle();
        check_val("stl_pc1",   PC_OUT, 32'h4);
        check_val("stl_in1",   INSTRUCTION_OUT, 32'hBBBB_BBBB);
        cycle();
        check_val("stl_v_gap", {31'b0, VALID_OUT}, 32'h0);
        cycle();
        check_val("stl_pc2",   PC_OUT, 32'h8);
        check_val("stl_in2",   INSTRUCTION_OUT, 32'hCCCC_CCCC);

        // Redirect with two requests in flight.
        do_reset();
        imem.IMEM_GNT = 1'b1;
        mem_hold = 1'b1;
        cycle();
        cycle();
        check_val("rd_req_full", {31'b0, imem.IMEM_REQ}, 32'h0);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        mem_hold    = 1'b0;
        cycle();
        REDIRECT = 1'b0;
        #1;
        check_val("rd_flush1", {31'b0, FLUSH_OUT}, 32'h1);
        check_val("rd_addr",   imem.IMEM_ADDR, 32'h0000_0100);
        check_val("rd_v0",     {31'b0, VALID_OUT}, 32'h0);
        cycle();
        check_val("rd_flush0", {31'b0, FLUSH_OUT}, 32'h0);
        check_val("rd_v1",     {31'b0, VALID_OUT}, 32'h0);
        check_val("rd_req",    {31'b0, imem.IMEM_REQ}, 32'h1);
        cycle();
        check_val("rd_v2",     {31'b0, VALID_OUT}, 32'h0);
        check_val("rd_addr2",  imem.IMEM_ADDR, 32'h0000_0104);
        cycle();
        check_val("rd_v3",     {31'b0, VALID_OUT}, 32'h1);
        check_val("rd_pc",     PC_OUT, 32'h0000_0100);
        check_val("rd_in",     INSTRUCTION_OUT, 32'h5A5A_0100);

        // Redirect + stall in the same cycle as a response.
        do_reset();
        imem.IMEM_GNT = 1'b1;
        STALL = 1'b1;
        cycle();
        cycle();
        check_val("rs_v_pre",  {31'b0, VALID_OUT}, 32'h1);
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'h0000_0200;
        cycle();
        check_val("rs_v",      {31'b0, VALID_OUT}, 32'h0);
        check_val("rs_pc",     PC_OUT, 32'h0);
        check_val("rs_in",     INSTRUCTION_OUT, 32'h0);
        check_val("rs_flush",  {31'b0, FLUSH_OUT}, 32'h1);
        check_val("rs_addr",   imem.IMEM_ADDR, 32'h0000_0200);
        REDIRECT = 1'b0;
        STALL    = 1'b0;
        cycle();
        check_val("rs_v_next", {31'b0, VALID_OUT}, 32'h0);

        // PC wrap.
        do_reset();
        REDIRECT    = 1'b1;
        REDIRECT_PC = 32'hFFFF_FFFC;
        cycle();
        REDIRECT = 1'b0;
        imem.IMEM_GNT = 1'b1;
        #1;
        check_val("wr_addr0",  imem.IMEM_ADDR, 32'hFFFF_FFFC);
        check_val("wr_req",    {31'b0, imem.IMEM_REQ}, 32'h1);
        cycle();
        check_val("wr_addr1",  imem.IMEM_ADDR, 32'h0);
        cycle();
        check_val("wr_pc",     PC_OUT, 32'hFFFF_FFFC);
        check_val("wr_in",     INSTRUCTION_OUT, 32'hA5A5_FFFC);
        check_val("wr_addr2",  imem.IMEM_ADDR, 32'h4);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        imem.IMEM_RVALID = 1'b0;
        pending.delete();
        #1;
        check_val("ar_valid",  {31'b0, VALID_OUT}, 32'h0);
        check_val("ar_pc",     PC_OUT, 32'h0);
        check_val("ar_in",     INSTRUCTION_OUT, 32'h0);
        check_val("ar_addr",   imem.IMEM_ADDR, 32'h0);
        check_val("ar_req",    {31'b0, imem.IMEM_REQ}, 32'h0);
        check_val("ar_flush",  {31'b0, FLUSH_OUT}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("ar_addr_rel", imem.IMEM_ADDR, 32'h0);
        check_val("ar_req_rel",  {31'b0, imem.IMEM_REQ}, 32'h1);
        cycle();
        check_val("ar_addr_nxt", imem.IMEM_ADDR, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
